atm_session_arbiter: RTL and testbench

//  Shares one ATM controller transaction datapath between NUM_TERM card-reader terminals.

---
 rtl/atm_session_arbiter_if.sv | 35 +++
 rtl/atm_session_arbiter.sv | 135 +++++++++++++
 tb/tb_atm_session_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_session_arbiter_if.sv
// Signal bundle between the terminal front-ends / ATM controller and the session arbiter.
// The master side drives requests and controller status; the slave side is the arbiter.
interface atm_session_arbiter_if #(
  parameter int NUM_TERM = 4
);
  logic [NUM_TERM-1:0]   req;
  logic [5*NUM_TERM-1:0] term_account;
  logic [4*NUM_TERM-1:0] term_pin;
  logic [3*NUM_TERM-1:0] term_amount;
  logic [2*NUM_TERM-1:0] term_op;
  logic                  ctl_done;
  logic                  ctl_ok;
  logic [NUM_TERM-1:0]   gnt;
  logic                  busy;
  logic                  ctl_start;
  logic                  ctl_abort;
  logic [4:0]            ctl_account;
  logic [3:0]            ctl_pin;
  logic [2:0]            ctl_amount;
  logic [1:0]            ctl_op;
  logic [NUM_TERM-1:0]   term_done;
  logic [NUM_TERM-1:0]   term_ok;

  modport master (
    output req, term_account, term_pin, term_amount, term_op, ctl_done, ctl_ok,
    input  gnt, busy, ctl_start, ctl_abort, ctl_account, ctl_pin, ctl_amount, ctl_op,
           term_done, term_ok
  );

  modport slave (
    input  req, term_account, term_pin, term_amount, term_op, ctl_done, ctl_ok,
    output gnt, busy, ctl_start, ctl_abort, ctl_account, ctl_pin, ctl_amount, ctl_op,
           term_done, term_ok
  );
endinterface

// File: rtl/atm_session_arbiter.sv
// Round-robin session arbiter sharing one ATM controller datapath between NUM_TERM terminals.
// All outputs are registered from the next-state decode; reset is asynchronous and active-low.
module atm_session_arbiter #(
  parameter int NUM_TERM = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  atm_session_arbiter_if.slave sess
);
  localparam int IDX_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ABORT} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    last, last_nxt;
  logic [IDX_W-1:0]    sel, sel_nxt;
  logic [IDX_W-1:0]    win;
  logic                win_vld;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [NUM_TERM-1:0] ok_nxt;
  logic [4:0]          account_mux;
  logic [3:0]          pin_mux;
  logic [2:0]          amount_mux;
  logic [1:0]          op_mux;

  // Search begins just after the previous winner so a re-requesting terminal is considered last.
  always_comb begin
    win     = last;
    win_vld = 1'b0;
    for (int k = 1; k <= NUM_TERM; k++) begin
      if (!win_vld && sess.req[IDX_W'((int'(last) + k) % NUM_TERM)]) begin
        win     = IDX_W'((int'(last) + k) % NUM_TERM);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    account_mux = '0;
    pin_mux     = '0;
    amount_mux  = '0;
    op_mux      = '0;
    for (int i = 0; i < NUM_TERM; i++) begin
      if (win == IDX_W'(i)) begin
        account_mux = sess.term_account[5*i +: 5];
        pin_mux     = sess.term_pin[4*i +: 4];
        amount_mux  = sess.term_amount[3*i +: 3];
        op_mux      = sess.term_op[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
    timer_nxt = timer;
    ok_nxt    = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = LOAD;
          sel_nxt   = win;
          last_nxt  = win;
        end
      end
      LOAD: begin
        state_nxt = RUN;
        timer_nxt = '0;
      end
      RUN: begin
        // Completion outranks card removal and timeout when they coincide.
        if (sess.ctl_done) begin
          state_nxt = DONE;
          ok_nxt    = sess.gnt & {NUM_TERM{sess.ctl_ok}};
        end else if (!sess.req[sel]) begin
          state_nxt = ABORT;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_nxt = ABORT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DONE, ABORT: state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= IDX_W'(NUM_TERM - 1);
      sel   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      sel   <= sel_nxt;
      timer <= timer_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sess.gnt         <= '0;
      sess.busy        <= 1'b0;
      sess.ctl_start   <= 1'b0;
      sess.ctl_abort   <= 1'b0;
      sess.ctl_account <= '0;
      sess.ctl_pin     <= '0;
      sess.ctl_amount  <= '0;
      sess.ctl_op      <= '0;
      sess.term_done   <= '0;
      sess.term_ok     <= '0;
    end else begin
      sess.busy      <= (state_nxt != IDLE);
      sess.ctl_start <= (state_nxt == LOAD);
      sess.ctl_abort <= (state_nxt == ABORT);
      sess.term_ok   <= ok_nxt;
      sess.term_done <= (state_nxt == DONE || state_nxt == ABORT) ? sess.gnt : '0;
      // Snapshot is taken once at grant time and left in place after the session ends.
      if (state_nxt == LOAD) begin
        sess.gnt         <= {{(NUM_TERM-1){1'b0}}, 1'b1} << win;
        sess.ctl_account <= account_mux;
        sess.ctl_pin     <= pin_mux;
        sess.ctl_amount  <= amount_mux;
        sess.ctl_op      <= op_mux;
      end else if (state_nxt == IDLE) begin
        sess.gnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_atm_session_arbiter.sv
// Bench for atm_session_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a session-level reference model.
module tb_atm_session_arbiter;
  localparam int NT = 4;
  localparam int TO = 16;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  atm_session_arbiter_if #(.NUM_TERM(NT)) bus ();

  atm_session_arbiter #(.NUM_TERM(NT), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .sess (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference arbitration: first requester after the previous winner, wrapping.
  function automatic int rr_pick(input logic [NT-1:0] r, input int prev);
    for (int k = 1; k <= NT; k++) begin
      if (((r >> ((prev + k) % NT)) & NT'(1)) != '0) return (prev + k) % NT;
    end
    return -1;
  endfunction

  // Session-level reference model: one active session at a time, tracked by
  // winner index, a started flag, a RUN-cycle count and an ending flag.
  logic          m_active  = 1'b0;
  logic          m_running = 1'b0;
  logic          m_end     = 1'b0;
  int            m_win     = 0;
  int            m_last    = NT - 1;
  int            m_run     = 0;
  logic [NT-1:0] e_gnt     = '0;
  logic          e_busy    = 1'b0;
  logic          e_start   = 1'b0;
  logic          e_abort   = 1'b0;
  logic [4:0]    e_acc     = '0;
  logic [3:0]    e_pin     = '0;
  logic [2:0]    e_amt     = '0;
  logic [1:0]    e_op      = '0;
  logic [NT-1:0] e_done    = '0;
  logic [NT-1:0] e_ok      = '0;

  always @(posedge clk or negedge rst) begin : model
    int w;
    if (!rst) begin
      m_active  <= 1'b0;
      m_running <= 1'b0;
      m_end     <= 1'b0;
      m_last    <= NT - 1;
      m_run     <= 0;
      e_gnt     <= '0;
      e_busy    <= 1'b0;
      e_start   <= 1'b0;
      e_abort   <= 1'b0;
      e_acc     <= '0;
      e_pin     <= '0;
      e_amt     <= '0;
      e_op      <= '0;
      e_done    <= '0;
      e_ok      <= '0;
    end else begin
      e_start <= 1'b0;
      e_abort <= 1'b0;
      e_done  <= '0;
      e_ok    <= '0;
      if (!m_active) begin
        if (bus.req != '0) begin
          w = rr_pick(bus.req, m_last);
          m_last    <= w;
          m_win     <= w;
          m_active  <= 1'b1;
          m_running <= 1'b0;
          m_end     <= 1'b0;
          e_gnt     <= NT'(1) << w;
          e_busy    <= 1'b1;
          e_start   <= 1'b1;
          e_acc     <= 5'(bus.term_account >> (5 * w));
          e_pin     <= 4'(bus.term_pin >> (4 * w));
          e_amt     <= 3'(bus.term_amount >> (3 * w));
          e_op      <= 2'(bus.term_op >> (2 * w));
        end
      end else if (m_end) begin
        m_active <= 1'b0;
        m_end    <= 1'b0;
        e_gnt    <= '0;
        e_busy   <= 1'b0;
      end else if (!m_running) begin
        m_running <= 1'b1;
        m_run     <= 0;
      end else if (bus.ctl_done) begin
        e_done    <= e_gnt;
        e_ok      <= bus.ctl_ok ? e_gnt : '0;
        m_end     <= 1'b1;
        m_running <= 1'b0;
      end else if (((bus.req >> m_win) & NT'(1)) == '0 || m_run == TO - 1) begin
        e_done    <= e_gnt;
        e_abort   <= 1'b1;
        m_end     <= 1'b1;
        m_running <= 1'b0;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt",         32'(bus.gnt),         32'(e_gnt));
    chk("busy",        32'(bus.busy),        32'(e_busy));
    chk("ctl_start",   32'(bus.ctl_start),   32'(e_start));
    chk("ctl_abort",   32'(bus.ctl_abort),   32'(e_abort));
    chk("ctl_account", 32'(bus.ctl_account), 32'(e_acc));
    chk("ctl_pin",     32'(bus.ctl_pin),     32'(e_pin));
    chk("ctl_amount",  32'(bus.ctl_amount),  32'(e_amt));
    chk("ctl_op",      32'(bus.ctl_op),      32'(e_op));
    chk("term_done",   32'(bus.term_done),   32'(e_done));
    chk("term_ok",     32'(bus.term_ok),     32'(e_ok));
    chk("gnt_onehot",  32'($onehot0(bus.gnt)), 32'd1);
  end

  task automatic do_reset();
    rst          = 1'b0;
    bus.req      = '0;
    bus.ctl_done = 1'b0;
    bus.ctl_ok   = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      step();
      if (!bus.busy) return;
    end
    bound_fail(name);
  endtask

  logic [NT-1:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NT-1:0] flip;
  int            starts;
  int            runs;
  logic          got;

  initial begin
    rst              = 1'b0;
    bus.req          = 4'b1111;
    bus.term_account = '0;
    bus.term_pin     = '0;
    bus.term_amount  = '0;
    bus.term_op      = '0;
    bus.ctl_done     = 1'b0;
    bus.ctl_ok       = 1'b0;

    chk("rr_pick_a", 32'(rr_pick(4'b1010, 3)), 32'd1);
    chk("rr_pick_b", 32'(rr_pick(4'b1010, 1)), 32'd3);
    chk("rr_pick_c", 32'(rr_pick(4'b0001, 0)), 32'd0);

    // Reset holds everything low even with all terminals requesting.
    repeat (3) begin
      step();
      chk("t1_gnt", 32'(bus.gnt), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd0);
      chk("t1_start", 32'(bus.ctl_start), 32'd0);
    end
    rst = 1'b1;
    step();
    chk("t1_first_gnt", 32'(bus.gnt), 32'b0001);
    chk("t1_first_start", 32'(bus.ctl_start), 32'd1);
    bus.req = '0;
    wait_idle("t1_idle", 40);

    // Single session on terminal 2.
    do_reset();
    bus.req          = 4'b0100;
    bus.term_account = 20'b00000_11111_00000_00000;
    bus.term_pin     = 16'h0F00;
    bus.term_amount  = 12'b000_011_000_000;
    bus.term_op      = 8'b00_01_00_00;
    step();
    chk("t2_gnt", 32'(bus.gnt), 32'b0100);
    chk("t2_start", 32'(bus.ctl_start), 32'd1);
    chk("t2_account", 32'(bus.ctl_account), 32'b11111);
    chk("t2_pin", 32'(bus.ctl_pin), 32'b1111);
    chk("t2_amount", 32'(bus.ctl_amount), 32'b011);
    chk("t2_op", 32'(bus.ctl_op), 32'b01);
    bus.term_account = '0;
    bus.term_pin     = '0;
    step();
    chk("t2_start_low", 32'(bus.ctl_start), 32'd0);
    bus.ctl_done = 1'b1;
    bus.ctl_ok   = 1'b1;
    step();
    bus.ctl_done = 1'b0;
    bus.req      = '0;
    chk("t2_term_done", 32'(bus.term_done), 32'b0100);
    chk("t2_term_ok", 32'(bus.term_ok), 32'b0100);
    chk("t2_no_abort", 32'(bus.ctl_abort), 32'd0);
    chk("t2_hold_account", 32'(bus.ctl_account), 32'b11111);
    step();
    chk("t2_gnt_clear", 32'(bus.gnt), 32'd0);
    chk("t2_busy_clear", 32'(bus.busy), 32'd0);
    chk("t2_retain_pin", 32'(bus.ctl_pin), 32'b1111);

    // Fairness with all terminals holding requests.
    do_reset();
    bus.req = 4'b1111;
    starts  = 0;
    for (int s = 0; s < 5; s++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        step();
        if (bus.ctl_start) begin
          got = 1'b1;
          starts++;
        end
      end
      if (!got) bound_fail("t3_start_wait");
      chk("t3_order", 32'(bus.gnt), 32'(exp_order[s]));
      step();
      bus.ctl_done = 1'b1;
      bus.ctl_ok   = 1'b1;
      if (s == 4) bus.req = '0;
      step();
      bus.ctl_done = 1'b0;
      chk("t3_done", 32'(bus.term_done), 32'(exp_order[s]));
    end
    repeat (4) begin
      step();
      if (bus.ctl_start) starts++;
    end
    chk("t3_start_count", 32'(starts), 32'd5);

    // Timeout on terminal 1.
    do_reset();
    bus.req = 4'b0010;
    step();
    chk("t4_gnt", 32'(bus.gnt), 32'b0010);
    runs = 0;
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (bus.ctl_abort) got = 1'b1;
      else runs++;
    end
    if (!got) bound_fail("t4_abort_wait");
    chk("t4_run_cycles", 32'(runs), 32'd16);
    chk("t4_term_done", 32'(bus.term_done), 32'b0010);
    chk("t4_term_ok", 32'(bus.term_ok), 32'd0);
    bus.req = '0;
    step();
    chk("t4_abort_pulse", 32'(bus.ctl_abort), 32'd0);
    chk("t4_gnt_clear", 32'(bus.gnt), 32'd0);

    // Card removal on terminal 3.
    do_reset();
    bus.req = 4'b1000;
    step();
    step();
    step();
    bus.req = '0;
    step();
    chk("t5a_abort", 32'(bus.ctl_abort), 32'd1);
    chk("t5a_done", 32'(bus.term_done), 32'b1000);
    chk("t5a_ok", 32'(bus.term_ok), 32'd0);
    wait_idle("t5a_idle", 10);

    // Completion coinciding with removal.
    do_reset();
    bus.req = 4'b1000;
    step();
    step();
    bus.req      = '0;
    bus.ctl_done = 1'b1;
    bus.ctl_ok   = 1'b1;
    step();
    bus.ctl_done = 1'b0;
    chk("t5b_ok", 32'(bus.term_ok), 32'b1000);
    chk("t5b_no_abort", 32'(bus.ctl_abort), 32'd0);
    wait_idle("t5b_idle", 10);

    // Completion coinciding with the final timeout count.
    do_reset();
    bus.req = 4'b0010;
    step();
    repeat (16) step();
    bus.ctl_done = 1'b1;
    bus.ctl_ok   = 1'b1;
    step();
    bus.ctl_done = 1'b0;
    bus.req      = '0;
    chk("t5c_done", 32'(bus.term_done), 32'b0010);
    chk("t5c_ok", 32'(bus.term_ok), 32'b0010);
    chk("t5c_no_abort", 32'(bus.ctl_abort), 32'd0);
    wait_idle("t5c_idle", 10);

    // Asynchronous reset in the middle of a session.
    do_reset();
    bus.req          = 4'b1000;
    bus.term_account = 20'b10101_00000_00000_00000;
    step();
    step();
    chk("t6_gnt_before", 32'(bus.gnt), 32'b1000);
    rst = 1'b0;
    #1;
    chk("t6_gnt_async", 32'(bus.gnt), 32'd0);
    chk("t6_busy_async", 32'(bus.busy), 32'd0);
    chk("t6_account_async", 32'(bus.ctl_account), 32'd0);
    step();
    chk("t6_no_done", 32'(bus.term_done), 32'd0);
    chk("t6_no_abort", 32'(bus.ctl_abort), 32'd0);
    rst = 1'b1;
    step();
    chk("t6_fresh_gnt", 32'(bus.gnt), 32'b1000);
    chk("t6_fresh_account", 32'(bus.ctl_account), 32'b10101);
    step();
    bus.ctl_done = 1'b1;
    bus.ctl_ok   = 1'b0;
    step();
    bus.ctl_done = 1'b0;
    bus.req      = '0;
    chk("t6_fresh_done", 32'(bus.term_done), 32'b1000);
    chk("t6_fresh_ok", 32'(bus.term_ok), 32'd0);
    wait_idle("t6_idle", 10);

    // Randomized traffic; the per-cycle compare process carries the checking.
    do_reset();
    repeat (3000) begin
      step();
      flip = '0;
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(0, 11) == 0) flip = flip | (NT'(1) << i);
      end
      bus.req          = bus.req ^ flip;
      bus.term_account = 20'($urandom);
      bus.term_pin     = 16'($urandom);
      bus.term_amount  = 12'($urandom);
      bus.term_op      = 8'($urandom);
      bus.ctl_done     = ($urandom_range(0, 7) == 0);
      bus.ctl_ok       = 1'($urandom);
      rst              = ($urandom_range(0, 599) != 0);
    end
    rst          = 1'b1;
    bus.req      = '0;
    bus.ctl_done = 1'b0;
    repeat (25) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
